// File: rtl/ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ram_ctrl
// Description : Single-port word RAM with byte-lane writes, a valid/ready
//               request port, one-cycle responses and a zero-fill engine.
// Revision    : 1.0 - initial release
// ============================================================================

module ram_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wr,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  input  logic                clear,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                busy
);

  localparam int                c_lanes     = DATA_W / 8;
  localparam logic [ADDR_W-1:0] c_idx_last  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] c_idx_one   = ADDR_W'(1);
  localparam logic [ADDR_W:0]   c_depth_ext = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [0:0] {
    ST_FILL  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_fill_idx;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_rsp_err;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_req_ready;
  logic                w_accept;
  logic                w_in_range;

  // The extra top bit keeps the range test exact when DEPTH == 2**ADDR_W.
  assign w_in_range  = ({1'b0, req_addr} < c_depth_ext);
  assign w_req_ready = (r_state == ST_READY) && !clear;
  assign w_accept    = req_valid && w_req_ready;

  assign req_ready = w_req_ready;
  assign busy      = (r_state == ST_FILL);
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_FILL;
      r_fill_idx  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= w_accept;
      r_rsp_err   <= w_accept && !w_in_range;
      r_rsp_rdata <= (w_accept && !req_wr && w_in_range) ? r_mem[req_addr] : '0;
      case (r_state)
        ST_FILL: begin
          if (clear) begin
            r_fill_idx <= '0;
          end else if (r_fill_idx == c_idx_last) begin
            r_state    <= ST_READY;
            r_fill_idx <= '0;
          end else begin
            r_fill_idx <= r_fill_idx + c_idx_one;
          end
        end
        ST_READY: begin
          if (clear) begin
            r_state    <= ST_FILL;
            r_fill_idx <= '0;
          end
        end
        default: begin
          r_state    <= ST_FILL;
          r_fill_idx <= '0;
        end
      endcase
    end
  end

  // Storage has no reset; the fill engine defines its contents.
  always_ff @(posedge clock) begin
    if (r_state == ST_FILL) begin
      r_mem[r_fill_idx] <= '0;
    end else if (w_accept && req_wr && w_in_range) begin
      for (int i = 0; i < c_lanes; i++) begin
        if (req_be[i]) begin
          r_mem[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

`default_nettype wire
